// File: rtl/vga_ctrl_if.sv
// rtl/vga_ctrl_if.sv - pixel request and video output bundle of the VGA timing controller
interface vga_ctrl_if;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [15:0] pix_data;
  logic        hsync;
  logic        vsync;
  logic [15:0] rgb;
  logic        rgb_valid;
  logic        frame_start;

  modport master (
    output pix_x, pix_y, hsync, vsync, rgb, rgb_valid, frame_start,
    input  pix_data
  );

  modport slave (
    input  pix_x, pix_y, hsync, vsync, rgb, rgb_valid, frame_start,
    output pix_data
  );
endinterface

// File: rtl/vga_ctrl.sv
// rtl/vga_ctrl.sv - VGA timing generator with one-clock pixel request lookahead
module vga_ctrl #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_VALID = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_VALID = 480,
  parameter int V_FRONT = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  vga_ctrl_if.master bus
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_E  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_E  = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_B   = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT_E   = 10'(H_SYNC + H_BACK + H_VALID);
  localparam logic [9:0] H_REQ_B   = 10'(H_SYNC + H_BACK - 1);
  localparam logic [9:0] H_REQ_E   = 10'(H_SYNC + H_BACK + H_VALID - 1);
  localparam logic [9:0] V_ACT_B   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT_E   = 10'(V_SYNC + V_BACK + V_VALID);

  logic [9:0] r_cnt_h;
  logic [9:0] r_cnt_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_h <= '0;
      r_cnt_v <= '0;
    end else if (r_cnt_h == H_LAST) begin
      r_cnt_h <= '0;
      r_cnt_v <= (r_cnt_v == V_LAST) ? '0 : r_cnt_v + 10'd1;
    end else begin
      r_cnt_h <= r_cnt_h + 10'd1;
    end
  end

  logic       w_v_act;
  logic       w_h_act;
  logic       w_h_req;
  logic       w_pix_req;
  logic       w_rgb_valid;
  logic [9:0] w_pix_x;
  logic [9:0] w_pix_y;

  assign w_v_act     = (r_cnt_v >= V_ACT_B) && (r_cnt_v < V_ACT_E);
  assign w_h_act     = (r_cnt_h >= H_ACT_B) && (r_cnt_h < H_ACT_E);
  // Requests lead the visible window by one clock to cover the generator's register stage.
  assign w_h_req     = (r_cnt_h >= H_REQ_B) && (r_cnt_h < H_REQ_E);
  assign w_pix_req   = w_h_req && w_v_act;
  assign w_rgb_valid = w_h_act && w_v_act;
  assign w_pix_x     = r_cnt_h - H_REQ_B;
  assign w_pix_y     = r_cnt_v - V_ACT_B;

  assign bus.hsync     = (r_cnt_h < H_SYNC_E);
  assign bus.vsync     = (r_cnt_v < V_SYNC_E);
  assign bus.rgb_valid = w_rgb_valid;
  assign bus.rgb       = w_rgb_valid ? bus.pix_data : 16'd0;
  assign bus.pix_x     = w_pix_req ? w_pix_x : 10'h3ff;
  assign bus.pix_y     = w_pix_req ? w_pix_y : 10'h3ff;
  // Gated by rst_n so the zero-count cycle held in reset does not pulse, but the
  // first cycle after release does.
  assign bus.frame_start = rst_n && (r_cnt_h == '0) && (r_cnt_v == '0);
endmodule

// File: tb/tb_vga_ctrl.sv
// tb/tb_vga_ctrl.sv - scoreboard bench for vga_ctrl on a reduced raster
module tb_vga_ctrl;
  localparam int HS = 4, HB = 3, HV = 8, HF = 2;
  localparam int VS = 2, VB = 3, VV = 4, VF = 2;
  localparam int HT = HS + HB + HV + HF;
  localparam int VT = VS + VB + VV + VF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic r_force = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   mh = 0;
  int   mv = 0;
  logic [15:0] sb[$];
  int   n_fs = 0, n_hs = 0, n_vs = 0, n_valid = 0;
  int   since_rel = 0;
  int   first_valid = -1;
  bit   track = 0;

  always #5 clk = ~clk;

  vga_ctrl_if u_if ();

  vga_ctrl #(
    .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if.master)
  );

  always @(posedge clk)
    u_if.pix_data <= r_force ? 16'hffff : {u_if.pix_y[4:0], u_if.pix_x[5:0], u_if.pix_x[4:0]};

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h (h=%0d v=%0d)", tag, obs, exp, mh, mv);
    end
  endtask

  task automatic cycle();
    logic e_hs, e_vs, e_val, e_req, e_fs, v_act;
    logic [9:0]  e_x, e_y;
    logic [15:0] e_rgb;
    @(negedge clk);
    v_act = (mv >= VS + VB) && (mv < VS + VB + VV);
    e_hs  = (mh < HS);
    e_vs  = (mv < VS);
    e_val = (mh >= HS + HB) && (mh < HS + HB + HV) && v_act;
    e_req = (mh >= HS + HB - 1) && (mh < HS + HB + HV - 1) && v_act;
    e_x   = e_req ? 10'(mh - (HS + HB - 1)) : 10'h3ff;
    e_y   = e_req ? 10'(mv - (VS + VB)) : 10'h3ff;
    e_fs  = rst_n && (mh == 0) && (mv == 0);
    e_rgb = 16'd0;
    if (e_val) begin
      if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
      else e_rgb = sb.pop_front();
    end
    chk("hsync", 32'(u_if.hsync), 32'(e_hs));
    chk("vsync", 32'(u_if.vsync), 32'(e_vs));
    chk("rgb_valid", 32'(u_if.rgb_valid), 32'(e_val));
    chk("pix_x", 32'(u_if.pix_x), 32'(e_x));
    chk("pix_y", 32'(u_if.pix_y), 32'(e_y));
    chk("frame_start", 32'(u_if.frame_start), 32'(e_fs));
    chk("rgb", 32'(u_if.rgb), 32'(e_rgb));
    if (e_req) sb.push_back({e_y[4:0], e_x[5:0], e_x[4:0]});
    n_fs    += int'(u_if.frame_start);
    n_hs    += int'(u_if.hsync);
    n_vs    += int'(u_if.vsync);
    n_valid += int'(u_if.rgb_valid);
    if (track) begin
      if (u_if.rgb_valid === 1'b1 && first_valid < 0) first_valid = since_rel;
      since_rel++;
    end
    @(posedge clk);
    if (rst_n) begin
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic run_until(input int h, input int v);
    int b = 0;
    while (!(mh == h && mv == v) && b <= HT * VT) begin
      cycle();
      b++;
    end
    if (!(mh == h && mv == v)) chk("run_until_timeout", 32'(b), 32'(HT * VT));
  endtask

  initial begin
    // Held in reset: zero counters, no requests, no frame pulse.
    run(3);

    rst_n = 1'b1;
    n_fs = 0; n_hs = 0; n_vs = 0; n_valid = 0;
    run(2 * HT * VT);
    chk("frames_fs_count", 32'(n_fs), 32'd2);
    chk("frames_hsync_clks", 32'(n_hs), 32'(2 * VT * HS));
    chk("frames_vsync_clks", 32'(n_vs), 32'(2 * VS * HT));
    chk("frames_valid_pix", 32'(n_valid), 32'(2 * HV * VV));

    // Generator forced to all-ones through a front-porch line: nothing may leak.
    run_until(0, VS + VB + VV);
    r_force = 1'b1;
    run(HT);
    r_force = 1'b0;

    // Mid-frame reset inside the active area.
    run_until(HS + HB + 1, VS + VB + 1);
    rst_n = 1'b0;
    mh = 0;
    mv = 0;
    sb.delete();
    #1;
    chk("rst_now_valid", 32'(u_if.rgb_valid), 32'd0);
    chk("rst_now_rgb", 32'(u_if.rgb), 32'd0);
    chk("rst_now_pix_x", 32'(u_if.pix_x), 32'h3ff);
    chk("rst_now_pix_y", 32'(u_if.pix_y), 32'h3ff);
    chk("rst_now_fs", 32'(u_if.frame_start), 32'd0);
    chk("rst_now_hsync", 32'(u_if.hsync), 32'd1);
    chk("rst_now_vsync", 32'(u_if.vsync), 32'd1);
    run(3);
    rst_n = 1'b1;
    track = 1;
    first_valid = -1;
    since_rel = 0;
    n_fs = 0;
    run((VS + VB) * HT + HS + HB + HT);
    chk("restart_latency", 32'(first_valid), 32'((VS + VB) * HT + HS + HB));
    chk("restart_fs_count", 32'(n_fs), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
